// File: rtl/host_mem_responder.sv
// Host-side memory responder: serves single and burst read/write beats from a word-addressed
// backing store with programmable latency, and counts beats and protocol errors.
module host_mem_responder #(
    parameter int unsigned MEM_WORDS = 16384,
    parameter int unsigned ADDR_WID  = 14,
    parameter logic [63:0] BASE_ADDR = 64'd0,
    parameter int unsigned RD_LAT    = 4,
    parameter int unsigned WR_LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_enable,
    input  logic [63:0] read_addr,
    input  logic [63:0] read_size,
    input  logic        finish_read,
    input  logic        write_enable,
    input  logic [63:0] write_addr,
    input  logic [63:0] write_size,
    input  logic [31:0] write_data,
    input  logic        finish_write,
    output logic [63:0] read_ready,
    output logic [31:0] read_data,
    output logic [63:0] write_ready,
    output logic        busy,
    output logic [31:0] rd_beats,
    output logic [31:0] wr_beats,
    output logic [15:0] err_count
);

    typedef enum logic [2:0] {StIdle, StRdWait, StRdAck, StWrWait, StWrAck} state_e;

    localparam logic [63:0] SPAN     = 64'(MEM_WORDS) << 2;
    localparam logic [15:0] RD_LAT_C = 16'(RD_LAT);
    localparam logic [15:0] WR_LAT_C = 16'(WR_LAT);

    function automatic logic addr_bad(input logic [63:0] addr);
        return (addr < BASE_ADDR) || ((addr - BASE_ADDR) >= SPAN) || (addr[1:0] != 2'b00);
    endfunction

    function automatic logic [ADDR_WID-1:0] addr_idx(input logic [63:0] addr);
        return ADDR_WID'((addr - BASE_ADDR) >> 2);
    endfunction

    logic [31:0] mem [MEM_WORDS];

    state_e              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [ADDR_WID-1:0] idx_q, idx_d;
    logic                bad_q, bad_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                pend_q, pend_d;
    logic [ADDR_WID-1:0] pend_idx_q, pend_idx_d;
    logic                pend_bad_q, pend_bad_d;
    logic [31:0]         pend_data_q, pend_data_d;
    logic [31:0]         rdata_q;
    logic [31:0]         rd_beats_q, wr_beats_q;
    logic [15:0]         err_q;

    logic        rd_term, wr_term, rd_fire, wr_fire;
    logic        size_err_rd, size_err_wr, range_err, fin_rd_err, fin_wr_err;
    logic [2:0]  err_inc;
    logic [16:0] err_sum;
    logic [31:0] rd_value;

    assign rd_term = (state_q == StRdWait) && (cnt_q == 16'd1);
    assign wr_term = (state_q == StWrWait) && (cnt_q == 16'd1);
    // A reset in the terminal cycle aborts the beat: no ready pulse, no memory write.
    assign rd_fire = rd_term && !reset;
    assign wr_fire = wr_term && !reset;

    assign range_err  = (rd_term || wr_term) && bad_q;
    assign fin_rd_err = finish_read && (state_q inside {StIdle, StRdWait, StWrWait});
    assign fin_wr_err = finish_write && (state_q inside {StIdle, StRdWait, StWrWait});

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        bad_d       = bad_q;
        wdata_d     = wdata_q;
        pend_d      = pend_q;
        pend_idx_d  = pend_idx_q;
        pend_bad_d  = pend_bad_q;
        pend_data_d = pend_data_q;
        size_err_rd = 1'b0;
        size_err_wr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pend_q) begin
                    state_d = StWrWait;
                    cnt_d   = WR_LAT_C;
                    idx_d   = pend_idx_q;
                    bad_d   = pend_bad_q;
                    wdata_d = pend_data_q;
                    pend_d  = 1'b0;
                end else if (read_enable) begin
                    state_d     = StRdWait;
                    cnt_d       = RD_LAT_C;
                    idx_d       = addr_idx(read_addr);
                    bad_d       = addr_bad(read_addr);
                    size_err_rd = (read_size != 64'd4);
                    // Tie: the write waits in the pending slot until the read burst ends.
                    if (write_enable) begin
                        pend_d      = 1'b1;
                        pend_idx_d  = addr_idx(write_addr);
                        pend_bad_d  = addr_bad(write_addr);
                        pend_data_d = write_data;
                        size_err_wr = (write_size != 64'd4);
                    end
                end else if (write_enable) begin
                    state_d     = StWrWait;
                    cnt_d       = WR_LAT_C;
                    idx_d       = addr_idx(write_addr);
                    bad_d       = addr_bad(write_addr);
                    wdata_d     = write_data;
                    size_err_wr = (write_size != 64'd4);
                end
            end
            StRdWait: begin
                cnt_d = cnt_q - 16'd1;
                if (rd_term) state_d = StRdAck;
            end
            StRdAck: begin
                if (finish_read) begin
                    state_d     = StRdWait;
                    cnt_d       = RD_LAT_C;
                    idx_d       = addr_idx(read_addr);
                    bad_d       = addr_bad(read_addr);
                    size_err_rd = (read_size != 64'd4);
                end else if (!read_enable) begin
                    state_d = StIdle;
                end
            end
            StWrWait: begin
                cnt_d = cnt_q - 16'd1;
                if (wr_term) state_d = StWrAck;
            end
            StWrAck: begin
                if (finish_write) begin
                    state_d     = StWrWait;
                    cnt_d       = WR_LAT_C;
                    idx_d       = addr_idx(write_addr);
                    bad_d       = addr_bad(write_addr);
                    wdata_d     = write_data;
                    size_err_wr = (write_size != 64'd4);
                end else if (!write_enable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign err_inc = 3'(size_err_rd) + 3'(size_err_wr) + 3'(range_err) + 3'(fin_rd_err)
                   + 3'(fin_wr_err);
    assign err_sum = {1'b0, err_q} + 17'(err_inc);

    assign rd_value = bad_q ? 32'h0 : mem[idx_q];

    always_ff @(posedge clk) begin
        if (wr_fire && !bad_q) mem[idx_q] <= wdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            bad_q       <= 1'b0;
            wdata_q     <= '0;
            pend_q      <= 1'b0;
            pend_idx_q  <= '0;
            pend_bad_q  <= 1'b0;
            pend_data_q <= '0;
            rdata_q     <= '0;
            rd_beats_q  <= '0;
            wr_beats_q  <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            bad_q       <= bad_d;
            wdata_q     <= wdata_d;
            pend_q      <= pend_d;
            pend_idx_q  <= pend_idx_d;
            pend_bad_q  <= pend_bad_d;
            pend_data_q <= pend_data_d;
            if (rd_term) rdata_q <= rd_value;
            if (rd_term && (rd_beats_q != '1)) rd_beats_q <= rd_beats_q + 32'd1;
            if (wr_term && (wr_beats_q != '1)) wr_beats_q <= wr_beats_q + 32'd1;
            err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign read_ready  = {63'd0, rd_fire};
    assign write_ready = {63'd0, wr_fire};
    assign read_data   = rd_fire ? rd_value : rdata_q;
    assign busy        = (state_q != StIdle);
    assign rd_beats    = rd_beats_q;
    assign wr_beats    = wr_beats_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_host_mem_responder.sv
// Bench for host_mem_responder: a cycle-indexed transaction model predicts every ready pulse,
// read beat, counter and error, checked each cycle, plus hand-computed literal expectations.
module tb_host_mem_responder;

    localparam int unsigned W  = 256;
    localparam int unsigned AW = 8;
    localparam int unsigned RL = 4;
    localparam int unsigned WL = 2;
    localparam logic [63:0] BASE = 64'h1000;

    logic        clk, reset;
    logic        read_enable, finish_read, write_enable, finish_write;
    logic [63:0] read_addr, read_size, write_addr, write_size;
    logic [31:0] write_data;
    logic [63:0] read_ready, write_ready;
    logic [31:0] read_data, rd_beats, wr_beats;
    logic        busy;
    logic [15:0] err_count;

    host_mem_responder #(
        .MEM_WORDS(W), .ADDR_WID(AW), .BASE_ADDR(BASE), .RD_LAT(RL), .WR_LAT(WL)
    ) dut (
        .clk(clk), .reset(reset),
        .read_enable(read_enable), .read_addr(read_addr), .read_size(read_size),
        .finish_read(finish_read),
        .write_enable(write_enable), .write_addr(write_addr), .write_size(write_size),
        .write_data(write_data), .finish_write(finish_write),
        .read_ready(read_ready), .read_data(read_data), .write_ready(write_ready),
        .busy(busy), .rd_beats(rd_beats), .wr_beats(wr_beats), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;
    bit run_chk = 1'b0;

    // Model: expected events keyed by the cycle in which they must appear.
    bit          exp_rr [int];
    logic [31:0] exp_rd [int];
    bit          exp_wr [int];
    int          err_sched [int];
    logic [31:0] mmem [int];
    int          m_rd = 0, m_wr = 0, m_err = 0;
    logic [31:0] m_last = 32'h0;

    typedef struct { int c; logic [31:0] d; } seen_t;
    seen_t rd_seen [$];
    int    wr_seen [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_bad(input logic [63:0] a);
        return (a < BASE) || (a >= BASE + 64'(W) * 4) || (a[1:0] != 2'b00);
    endfunction

    function automatic int m_word(input logic [63:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic add_err(input int c, input int n);
        if (err_sched.exists(c)) err_sched[c] += n;
        else err_sched[c] = n;
    endtask

    task automatic sched_rd(input int t, input logic [63:0] a);
        exp_rr[t] = 1'b1;
        if (m_bad(a)) begin
            exp_rd[t] = 32'h0;
            add_err(t, 1);
        end else begin
            exp_rd[t] = mmem[m_word(a)];
        end
    endtask

    task automatic sched_wr(input int t, input logic [63:0] a, input logic [31:0] d);
        exp_wr[t] = 1'b1;
        if (m_bad(a)) add_err(t, 1);
        else mmem[m_word(a)] = d;
    endtask

    always @(negedge clk) begin : cmp
        bit rr, wr;
        logic [31:0] ed;
        if (run_chk) begin
            rr = exp_rr.exists(cyc);
            wr = exp_wr.exists(cyc);
            ed = rr ? exp_rd[cyc] : m_last;
            chk("read_ready", read_ready, {63'd0, rr});
            chk("read_data", {32'd0, read_data}, {32'd0, ed});
            chk("write_ready", write_ready, {63'd0, wr});
            chk("rd_beats", {32'd0, rd_beats}, 64'(m_rd));
            chk("wr_beats", {32'd0, wr_beats}, 64'(m_wr));
            chk("err_count", {48'd0, err_count}, 64'(m_err));
            if (read_ready[0]) rd_seen.push_back('{cyc, read_data});
            if (write_ready[0]) wr_seen.push_back(cyc);
            if (reset) begin
                m_rd = 0; m_wr = 0; m_err = 0; m_last = 32'h0;
            end else begin
                if (rr) begin m_rd++; m_last = ed; end
                if (wr) m_wr++;
                if (err_sched.exists(cyc)) m_err += err_sched[cyc];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_burst(input logic [63:0] a0, input int n, input logic [63:0] sz,
                            output int first);
        int t;
        first = cyc;
        read_enable = 1'b1; read_addr = a0; read_size = sz;
        if (sz != 64'd4) add_err(cyc, 1);
        t = cyc + int'(RL);
        for (int i = 0; i < n; i++) begin
            sched_rd(t, a0 + 64'(4 * i));
            while (cyc < t + 1) step();
            if (i < n - 1) begin
                finish_read = 1'b1; read_addr = a0 + 64'(4 * (i + 1));
                if (sz != 64'd4) add_err(cyc, 1);
                t = cyc + int'(RL);
                step();
                finish_read = 1'b0;
            end else begin
                read_enable = 1'b0;
                step();
            end
        end
        read_size = 64'd4;
    endtask

    task automatic wr_burst(input logic [63:0] a0, input logic [31:0] d [4], input int n);
        int t;
        write_enable = 1'b1; write_addr = a0; write_data = d[0];
        t = cyc + int'(WL);
        for (int i = 0; i < n; i++) begin
            sched_wr(t, a0 + 64'(4 * i), d[i]);
            while (cyc < t + 1) step();
            if (i < n - 1) begin
                finish_write = 1'b1; write_addr = a0 + 64'(4 * (i + 1)); write_data = d[i + 1];
                t = cyc + int'(WL);
                step();
                finish_write = 1'b0;
            end else begin
                write_enable = 1'b0;
                step();
            end
        end
    endtask

    task automatic do_write(input logic [63:0] a, input logic [31:0] d);
        logic [31:0] v [4];
        v[0] = d; v[1] = 32'h0; v[2] = 32'h0; v[3] = 32'h0;
        wr_burst(a, v, 1);
    endtask

    initial begin
        int c;
        logic [31:0] v [4];
        reset = 1'b1;
        read_enable = 1'b0; finish_read = 1'b0; write_enable = 1'b0; finish_write = 1'b0;
        read_addr = '0; write_addr = '0; write_data = '0;
        read_size = 64'd4; write_size = 64'd4;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        run_chk = 1'b1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_rd_beats", {32'd0, rd_beats}, 64'd0);
        chk("reset_read_data", {32'd0, read_data}, 64'd0);
        step();

        // Preload memory.
        do_write(BASE + 20, 32'hCAFE0005);
        v[0] = 32'hA0000000; v[1] = 32'hA1111111; v[2] = 32'hA2222222; v[3] = 32'hA3333333;
        wr_burst(BASE, v, 4);
        do_write(BASE + 64'(4 * (W - 1)), 32'h5EEDFFFF);
        chk("preload_wr_beats", {32'd0, wr_beats}, 64'd6);

        // Single read.
        rd_seen.delete();
        rd_burst(BASE + 20, 1, 64'd4, c);
        chk("single_cnt", 64'(rd_seen.size()), 64'd1);
        chk("single_cycle", 64'(rd_seen[0].c), 64'(c + 4));
        chk("single_data", {32'd0, rd_seen[0].d}, 64'hCAFE0005);
        chk("single_idle", {63'd0, busy}, 64'd0);

        // Read burst of four.
        rd_seen.delete();
        rd_burst(BASE, 4, 64'd4, c);
        chk("burst_cnt", 64'(rd_seen.size()), 64'd4);
        chk("burst_c0", 64'(rd_seen[0].c), 64'(c + 4));
        chk("burst_c1", 64'(rd_seen[1].c), 64'(c + 9));
        chk("burst_c2", 64'(rd_seen[2].c), 64'(c + 14));
        chk("burst_c3", 64'(rd_seen[3].c), 64'(c + 19));
        chk("burst_d3", {32'd0, rd_seen[3].d}, 64'hA3333333);
        chk("burst_rd_beats", {32'd0, rd_beats}, 64'd5);

        // Write burst then read back the middle word.
        v[0] = 32'd11; v[1] = 32'd22; v[2] = 32'd33; v[3] = 32'd0;
        wr_burst(BASE + 8, v, 3);
        chk("wburst_wr_beats", {32'd0, wr_beats}, 64'd9);
        rd_seen.delete();
        rd_burst(BASE + 12, 1, 64'd4, c);
        chk("wburst_read", {32'd0, rd_seen[0].d}, 64'd22);

        // Out-of-range accesses.
        rd_seen.delete();
        rd_burst(BASE + 64'(4 * W), 1, 64'd4, c);
        chk("oor_rd_ready", 64'(rd_seen.size()), 64'd1);
        chk("oor_rd_data", {32'd0, rd_seen[0].d}, 64'd0);
        chk("oor_rd_err", {48'd0, err_count}, 64'd1);
        do_write(BASE - 4, 32'hDEADBEEF);
        chk("oor_wr_err", {48'd0, err_count}, 64'd2);
        rd_seen.delete();
        rd_burst(BASE + 64'(4 * (W - 1)), 1, 64'd4, c);
        chk("oor_wr_untouched", {32'd0, rd_seen[0].d}, 64'h5EEDFFFF);

        // Bad size and stray finish pulses.
        rd_seen.delete();
        rd_burst(BASE + 20, 1, 64'd8, c);
        chk("size_data", {32'd0, rd_seen[0].d}, 64'hCAFE0005);
        chk("size_err", {48'd0, err_count}, 64'd3);
        finish_read = 1'b1; add_err(cyc, 1); step(); finish_read = 1'b0;
        finish_write = 1'b1; add_err(cyc, 1); step(); finish_write = 1'b0;
        step();
        chk("stray_err", {48'd0, err_count}, 64'd5);

        // Simultaneous read and write.
        rd_seen.delete();
        wr_seen.delete();
        c = cyc;
        read_enable = 1'b1; read_addr = BASE + 20;
        write_enable = 1'b1; write_addr = BASE + 40; write_data = 32'd77;
        sched_rd(c + int'(RL), BASE + 20);
        sched_wr(c + int'(RL) + 2 + int'(WL), BASE + 40, 32'd77);
        step();
        read_enable = 1'b0; write_enable = 1'b0;
        while (cyc < c + int'(RL) + int'(WL) + 4) step();
        chk("tie_rd_cycle", 64'(rd_seen[0].c), 64'(c + 4));
        chk("tie_wr_cycle", 64'(wr_seen[0]), 64'(c + 8));
        rd_seen.delete();
        rd_burst(BASE + 40, 1, 64'd4, c);
        chk("tie_readback", {32'd0, rd_seen[0].d}, 64'd77);

        // Reset in the read terminal cycle.
        c = cyc;
        read_enable = 1'b1; read_addr = BASE + 20;
        step();
        read_enable = 1'b0;
        while (cyc < c + int'(RL)) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_rd_ready", read_ready, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_rd_beats", {32'd0, rd_beats}, 64'd0);
        chk("rst_err", {48'd0, err_count}, 64'd0);

        // Reset in the write terminal cycle drops the write.
        c = cyc;
        write_enable = 1'b1; write_addr = BASE + 20; write_data = 32'h12345678;
        step();
        write_enable = 1'b0;
        while (cyc < c + int'(WL)) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_wr_ready", write_ready, 64'd0);
        rd_seen.delete();
        rd_burst(BASE + 20, 1, 64'd4, c);
        chk("rst_readback", {32'd0, rd_seen[0].d}, 64'hCAFE0005);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
